// File: rtl/team_06_sram_pkg.sv
// ----------------------------------------------------------------------------
// team_06_sram_pkg
// Shared types and constants for the audio delay-buffer SRAM scheduler.
//   state_t            : scheduler FSM states
//   gnt_t              : which requester owns the current transaction
//   DEFAULT_BASE_ADDR  : byte address of the circular buffer start
//   pickLane()         : extracts one byte lane from a 32-bit word
// ----------------------------------------------------------------------------
package team_06_sram_pkg;

    typedef enum logic [2:0] {
        RESYNC    = 3'd0,
        IDLE      = 3'd1,
        ISSUE     = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4,
        DONE      = 3'd5
    } state_t;

    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } gnt_t;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h3300_0000;

    // Byte lane 0 is the least significant byte of the bus word.
    function automatic logic [7:0] pickLane(input logic [31:0] word, input logic [1:0] lane);
        return word[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/team_06_sram_lane_map.sv
// ----------------------------------------------------------------------------
// team_06_sram_lane_map
// Combinational byte-address to word-access translation, shared by the write
// and read paths of the scheduler.
// Ports:
//   byteAddr_i : byte offset inside the circular buffer
//   adr_o      : word-aligned bus address (BASE_ADDR + byte offset, low bits 0)
//   sel_o      : one-hot byte-lane select
//   lane_o     : byte lane index (byteAddr_i[1:0])
// ----------------------------------------------------------------------------
module team_06_sram_lane_map
    import team_06_sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          PTR_W     = 12
) (
    input  logic [PTR_W-1:0] byteAddr_i,
    output logic [31:0]      adr_o,
    output logic [3:0]       sel_o,
    output logic [1:0]       lane_o
);

    // The word address drops the two lane bits; the lane bits instead pick
    // which of the four byte enables is raised.
    always_comb begin
        lane_o = byteAddr_i[1:0];
        sel_o  = 4'b0001 << byteAddr_i[1:0];
        adr_o  = BASE_ADDR + 32'({byteAddr_i[PTR_W-1:2], 2'b00});
    end

endmodule

// File: rtl/team_06_sram_scheduler.sv
// ----------------------------------------------------------------------------
// team_06_sram_scheduler
// Sequences all SRAM traffic for the audio delay/echo buffer. Arbitrates
// between sample record (write) and past-sample fetch (read), owns the
// circular write pointer and drives the wishbone manager one byte at a time.
//
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   enable                : low blocks new grants (in-flight ones finish)
//   wr_req/wr_data/wr_ack : sample record request, data, completion pulse
//   rd_req/rd_offset      : fetch request, distance back from newest sample
//   rd_data/rd_valid      : fetched sample (held) and its valid pulse
//   busy_i/rdata_i        : manager BUSY and read data
//   adr_o/wdata_o/sel_o   : word address, replicated write data, lane select
//   we_o/re_o             : one-cycle write / read strobes
//   wr_ptr                : next byte slot to be written
//   err                   : sticky "manager never went busy" flag
//
// Build option:
//   TEAM_06_SRAM_SCHED_RR_EN : round-robin arbitration when both requests are
//                              pending; otherwise write has fixed priority.
// ----------------------------------------------------------------------------
module team_06_sram_scheduler
    import team_06_sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          PTR_W     = 12,
    parameter int          TIMEOUT   = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             wr_req,
    input  logic [7:0]       wr_data,
    output logic             wr_ack,
    input  logic             rd_req,
    input  logic [PTR_W-1:0] rd_offset,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    input  logic             busy_i,
    input  logic [31:0]      rdata_i,
    output logic [31:0]      adr_o,
    output logic [31:0]      wdata_o,
    output logic [3:0]       sel_o,
    output logic             we_o,
    output logic             re_o,
    output logic [PTR_W-1:0] wr_ptr,
    output logic             err
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    gnt_t             gnt_q, gntPick;
    logic             grantNow, timedOut, pickRead, reqPending;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] wrPtr_q, rdByte, mapByte;
    logic [31:0]      adr_q, wdata_q, mapAdr;
    logic [3:0]       sel_q, mapSel;
    logic [1:0]       lane_q, mapLane;
    logic [7:0]       rdData_q;
    logic             err_q;
`ifdef TEAM_06_SRAM_SCHED_RR_EN
    logic             rrLastWr_q;
`endif

    // Arbitration and address selection. The read slot is counted back from
    // the write pointer; an offset of 0 would point at the not-yet-written
    // slot, so it is promoted to 1 (the newest recorded sample).
    always_comb begin
        reqPending = wr_req | rd_req;
`ifdef TEAM_06_SRAM_SCHED_RR_EN
        pickRead   = rd_req & (~wr_req | rrLastWr_q);
`else
        pickRead   = rd_req & ~wr_req;
`endif
        gntPick    = pickRead ? GNT_RD : GNT_WR;
        rdByte     = wrPtr_q - ((rd_offset == '0) ? PTR_W'(1) : rd_offset);
        mapByte    = pickRead ? rdByte : wrPtr_q;
    end

    team_06_sram_lane_map #(
        .BASE_ADDR (BASE_ADDR),
        .PTR_W     (PTR_W)
    ) u_lane_map (
        .byteAddr_i (mapByte),
        .adr_o      (mapAdr),
        .sel_o      (mapSel),
        .lane_o     (mapLane)
    );

    // Next-state logic. The timeout counter runs only while waiting for the
    // manager to acknowledge the strobe with BUSY; reaching CNT_LAST means
    // TIMEOUT cycles were spent in WAIT_BUSY.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        grantNow = 1'b0;
        timedOut = 1'b0;
        case (state_q)
            RESYNC: begin
                if (!busy_i) state_d = IDLE;
            end
            IDLE: begin
                if (enable && !busy_i && reqPending) begin
                    grantNow = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (busy_i) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    timedOut = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!busy_i) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = RESYNC;
            end
        endcase
    end

    // State register. Reset lands in RESYNC so a transfer the manager was
    // still running when we reset is allowed to drain first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESYNC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Transaction registers: address, lane select and write data are frozen
    // at grant so they are stable through ISSUE and held until DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q   <= GNT_WR;
            adr_q   <= '0;
            sel_q   <= '0;
            lane_q  <= '0;
            wdata_q <= '0;
        end else if (grantNow) begin
            gnt_q   <= gntPick;
            adr_q   <= mapAdr;
            sel_q   <= mapSel;
            lane_q  <= mapLane;
            wdata_q <= (gntPick == GNT_WR) ? {4{wr_data}} : 32'h0;
        end
    end

    // Pointer, read capture and error flag. A timed-out write still consumes
    // its slot so the delay line keeps its timing; a timed-out read returns 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q  <= '0;
            rdData_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state_q == DONE && gnt_q == GNT_WR) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (state_q == WAIT_DONE && !busy_i && gnt_q == GNT_RD) begin
                rdData_q <= pickLane(rdata_i, lane_q);
            end else if (timedOut && gnt_q == GNT_RD) begin
                rdData_q <= 8'h00;
            end
            if (timedOut) begin
                err_q <= 1'b1;
            end
        end
    end

`ifdef TEAM_06_SRAM_SCHED_RR_EN
    // Remembers who was served last so a contended grant goes to the other
    // requester; starts as "read last" so the first contended grant is a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rrLastWr_q <= 1'b0;
        end else if (grantNow) begin
            rrLastWr_q <= (gntPick == GNT_WR);
        end
    end
`endif

    assign we_o     = (state_q == ISSUE) && (gnt_q == GNT_WR);
    assign re_o     = (state_q == ISSUE) && (gnt_q == GNT_RD);
    assign wr_ack   = (state_q == DONE)  && (gnt_q == GNT_WR);
    assign rd_valid = (state_q == DONE)  && (gnt_q == GNT_RD);
    assign adr_o    = adr_q;
    assign sel_o    = sel_q;
    assign wdata_o  = wdata_q;
    assign rd_data  = rdData_q;
    assign wr_ptr   = wrPtr_q;
    assign err      = err_q;

endmodule

// File: doc/team_06_sram_scheduler.md
Name: team_06_sram_scheduler

Overview:
- Sequences all SRAM traffic for the audio delay/echo buffer.
- Arbitrates between two requesters: sample record (write) and past-sample fetch (read).
- Owns the circular-buffer write pointer and converts byte addresses into 32-bit word accesses with byte-lane selects.
- Sits between the audio effect datapath and the wishbone manager: drives the manager's data, address, select, write and read inputs, and consumes its read data and BUSY.

Parameters:
- BASE_ADDR, 32'h3300_0000, byte address of buffer start (word aligned)
- PTR_W, 12, buffer pointer width; depth = 2**PTR_W bytes
- TIMEOUT, 255, max cycles to wait for busy_i to rise after a strobe

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- enable  in  1  grant enable; low blocks new grants
- wr_req  in  1  level request to store wr_data
- wr_data  in  8  sample to record
- wr_ack  out  1  one-cycle pulse when the write completes
- rd_req  in  1  level request to fetch a past sample
- rd_offset  in  PTR_W  distance back from newest sample
- rd_data  out  8  fetched sample, held until next rd_valid
- rd_valid  out  1  one-cycle pulse, rd_data valid
- busy_i  in  1  manager BUSY
- rdata_i  in  32  manager read data
- adr_o  out  32  word address to manager
- wdata_o  out  32  write data to manager
- sel_o  out  4  byte-lane select to manager
- we_o  out  1  one-cycle write strobe
- re_o  out  1  one-cycle read strobe
- wr_ptr  out  PTR_W  next byte slot to be written
- err  out  1  sticky timeout flag

Behaviour:
- Reset values: all outputs 0; state = RESYNC; internal round-robin bit = 0.
- States:
  - RESYNC: stays until busy_i = 0 (manager may still be mid-transaction after reset), then goes to IDLE.
  - IDLE: if enable = 1 and busy_i = 0 and a request is pending, grant it and go to ISSUE.
  - ISSUE: one cycle; drive we_o or re_o = 1; adr_o, wdata_o and sel_o are already stable and held until DONE. Then go to WAIT_BUSY.
  - WAIT_BUSY: on busy_i = 1, go to WAIT_DONE. If TIMEOUT cycles elapse, set err and go to DONE.
  - WAIT_DONE: on busy_i = 0, go to DONE.
  - DONE: one cycle; pulse wr_ack or rd_valid; return to IDLE.
- Grant latency: wr_req seen in IDLE gives we_o in the next cycle.
- Request and acknowledge:
  - Requests are levels sampled only in IDLE.
  - wr_data and rd_offset are captured at grant.
  - A requester must deassert or change its request the cycle after its ack/valid; otherwise it is re-granted.
- Address math:
  - Write byte address b = wr_ptr.
  - Read b = (wr_ptr - max(rd_offset, 1)) mod 2**PTR_W; offset 0 is treated as 1 (newest sample).
  - adr_o = BASE_ADDR + {b[PTR_W-1:2], 2'b00}.
  - sel_o = 4'b0001 << b[1:0].
  - wdata_o = {4{sample}}.
  - rd_data = byte lane b[1:0] of rdata_i, captured when WAIT_DONE exits.
- Pointer: wr_ptr increments by 1 in DONE of every write, including timed-out writes. It wraps from 2**PTR_W-1 to 0.
- Timeout: rd_valid still pulses, with rd_data = 8'h00. err clears only on rst.
- enable low: an in-flight transaction completes normally; no new grant is made.
- Simultaneous requests: default is fixed priority, write wins (recording never drops samples).
- Reset mid-operation: strobes drop immediately; no ack or valid is issued for the aborted transfer.

Optional Feature:
- Macro: TEAM_06_SRAM_SCHED_RR_EN.
- Defined: round-robin arbitration. When both requests are pending, grant the requester not served last; the round-robin bit toggles on each grant. A single pending request is always granted.
- Undefined: fixed priority, write over read; no round-robin state is synthesized.

Decomposition:
- Shared package team_06_sram_pkg holds:
  - the state enum (RESYNC, IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE)
  - the grant type (GNT_WR, GNT_RD)
  - the default BASE_ADDR constant
- One sub-module, team_06_sram_lane_map: combinational byte address to {adr, sel, lane index}. It is shared by the write and read paths and unit-testable.

Test Plan:
- Write then read: after reset, write 8'h5A with a 3-cycle busy; then read with rd_offset = 1. Required: adr_o = 32'h3300_0000, sel_o = 4'b0001, wdata_o = 32'h5A5A5A5A; rd_valid with rd_data = 8'h5A; wr_ptr = 1.
- Lane mapping: five consecutive writes 8'h11..8'h55. Required: sel_o = 0001, 0010, 0100, 1000, 0001; adr_o steps to 32'h3300_0004 on the fifth write.
- Wrap: preload wr_ptr = 4095 via writes, write 8'hAA. Required: wr_ptr = 0; read with offset 1 gives adr_o = 32'h3300_0FFC, sel_o = 4'b1000.
- Contention: wr_req and rd_req held together. Default: write granted first and every time while wr_req is held. With RR_EN: grants alternate W, R, W, R.
- Timeout: busy_i stuck 0 after re_o. Required: rd_valid exactly 256 cycles after the strobe, rd_data = 8'h00, err = 1 and sticky.
- Reset mid-op: assert rst during WAIT_DONE with busy_i still 1. Required: outputs 0 immediately; no grant until busy_i falls; next write goes to wr_ptr = 0.
